// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions, FSM states.
package alu_pkg;

   localparam logic [3:0] OP_PASS = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_RSUB = 4'd3;
   localparam logic [3:0] OP_NEG  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_ROL  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   localparam int F_N = 3;
   localparam int F_Z = 2;
   localparam int F_C = 1;
   localparam int F_V = 0;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f      = '0;
      f[F_N] = n;
      f[F_Z] = z;
      f[F_C] = c;
      f[F_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: first partial product is taken on the start edge, so the
// product is ready (done pulses) WIDTH-1 clocks later.
module alu_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     m,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);
   import alu_pkg::*;

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_acc    <= m[0] ? {{WIDTH{1'b0}}, a} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            r_mplier <= m >> 1;
            r_cnt    <= CW'(WIDTH - 1);
            r_busy   <= 1'b1;
         end else if (r_busy) begin
            if (r_mplier[0]) begin
               r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign done = r_done;
   assign prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; single-cycle ops land one clock after
// accept, multiply goes through the shift-add unit with the FSM parked in MUL.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] m,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x,
   output logic [3:0]       flags
);
   import alu_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_state_next;
   logic               r_live;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_x;
   logic [3:0]         r_flags;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_prod;
   logic [SHW-1:0]     w_s;
   logic [WIDTH:0]     w_add;
   logic [WIDTH-1:0]   w_sub;
   logic [WIDTH-1:0]   w_rsub;
   logic [WIDTH:0]     w_shl;
   logic [WIDTH:0]     w_shr;
   logic [WIDTH:0]     w_sra;
   logic [2*WIDTH-1:0] w_rol;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic [3:0]         w_flags;
   logic [3:0]         w_mul_flags;

   // r_live keeps in_ready low while reset is held and for no longer than one clock after
   assign w_in_ready = r_live && (r_state == IDLE) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_is_mul   = (op == OP_MUL);

   assign w_s    = m[SHW-1:0];
   assign w_add  = {1'b0, a} + {1'b0, m};
   assign w_sub  = a - m;
   assign w_rsub = m - a;
   // Shifts carry one guard bit so the last bit shifted out falls into it
   assign w_shl  = {1'b0, a} << w_s;
   assign w_shr  = {a, 1'b0} >> w_s;
   assign w_sra  = $signed({a, 1'b0}) >>> w_s;
   assign w_rol  = {a, a} << w_s;

   always_comb begin
      w_res = a;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op)
         OP_PASS: w_res = a;
         OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (a[WIDTH-1] == m[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sub;
            w_c   = (a >= m);
            w_v   = (a[WIDTH-1] != m[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
         end
         OP_RSUB: begin
            w_res = w_rsub;
            w_c   = (m >= a);
            w_v   = (m[WIDTH-1] != a[WIDTH-1]) && (w_rsub[WIDTH-1] != m[WIDTH-1]);
         end
         OP_NEG:  w_res = -w_add[WIDTH-1:0];
         OP_AND:  w_res = a & m;
         OP_OR:   w_res = a | m;
         OP_XOR:  w_res = a ^ m;
         OP_SHL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res = w_shr[WIDTH:1];
            w_c   = w_shr[0];
         end
         OP_SRA: begin
            w_res = w_sra[WIDTH:1];
            w_c   = w_sra[0];
         end
         OP_ROL: begin
            w_res = w_rol[2*WIDTH-1:WIDTH];
            w_c   = (w_s != '0) && w_rol[WIDTH];
         end
         default: w_res = a;
      endcase
   end

   assign w_flags     = pack_flags(w_res[WIDTH-1], (w_res == '0), w_c, w_v);
   assign w_mul_flags = pack_flags(w_prod[WIDTH-1], (w_prod[WIDTH-1:0] == '0),
                                   (w_prod[2*WIDTH-1:WIDTH] != '0), 1'b0);

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_accept && w_is_mul),
      .a     (a),
      .m     (m),
      .done  (w_mul_done),
      .prod  (w_prod)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept && w_is_mul) w_state_next = MUL;
         MUL:     if (w_mul_done) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_live      <= 1'b0;
         r_out_valid <= 1'b0;
         r_x         <= '0;
         r_flags     <= '0;
      end else begin
         r_state <= w_state_next;
         r_live  <= 1'b1;
         if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_x         <= w_res;
            r_flags     <= w_flags;
         end else if ((r_state == MUL) && w_mul_done) begin
            r_out_valid <= 1'b1;
            r_x         <= w_prod[WIDTH-1:0];
            r_flags     <= w_mul_flags;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign x         = r_x;
   assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized bench for alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] m;
   logic [3:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] x;
   logic [3:0] flags;

   int n_vec = 0;
   int n_err = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .m         (m),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x         (x),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {flags[3:0], x[7:0]}, flags = {N,Z,C,V}
   function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] av,
                                         input logic [7:0] mv);
      int ai, mi, s, r, sa, sm, sr;
      bit c, v;
      logic [7:0] xr;
      ai = int'(av);
      mi = int'(mv);
      s  = mi % 8;
      sa = (ai >= 128) ? ai - 256 : ai;
      sm = (mi >= 128) ? mi - 256 : mi;
      c  = 0;
      v  = 0;
      case (o)
         4'd1:  begin r = ai + mi; c = (r >= 256); sr = sa + sm; v = (sr > 127) || (sr < -128); end
         4'd2:  begin r = ai - mi; c = (ai >= mi); sr = sa - sm; v = (sr > 127) || (sr < -128); end
         4'd3:  begin r = mi - ai; c = (mi >= ai); sr = sm - sa; v = (sr > 127) || (sr < -128); end
         4'd4:  r = -(ai + mi);
         4'd5:  r = ai & mi;
         4'd6:  r = ai | mi;
         4'd7:  r = ai ^ mi;
         4'd8:  begin r = ai << s; c = (s != 0) && (((ai >> (8 - s)) & 1) == 1); end
         4'd9:  begin r = ai >> s; c = (s != 0) && (((ai >> (s - 1)) & 1) == 1); end
         4'd10: begin r = sa >>> s; c = (s != 0) && (((sa >>> (s - 1)) & 1) == 1); end
         4'd11: begin r = (ai << s) | (ai >> (8 - s)); c = (s != 0) && ((r & 1) == 1); end
         4'd12: begin r = ai * mi; c = (r >= 256); end
         default: r = ai;
      endcase
      xr = r[7:0];
      return {xr[7], (xr == 8'h00), c, v, xr};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with out_ready=1, check timing and result; leaves bench #1 after the result edge
   task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] av,
                        input logic [7:0] mv);
      logic [11:0] exp;
      int cyc;
      bit rdy_bad;
      out_ready = 1'b1;
      op = o; a = av; m = mv; in_valid = 1'b1;
      for (int k = 0; k < 50 && !in_ready; k++) tick();
      if (!in_ready) chk({tag, "_wait_ready"}, 32'(in_ready), 32'd1);
      exp = model(o, av, mv);
      tick();
      in_valid = 1'b0;
      if (o == 4'd12) begin
         cyc = 1;
         rdy_bad = 0;
         while (!out_valid && cyc < 40) begin
            if (in_ready) rdy_bad = 1;
            tick();
            cyc++;
         end
         chk({tag, "_mul_lat"}, 32'(cyc), 32'd9);
         chk({tag, "_mul_ready"}, 32'(rdy_bad), 32'd0);
      end
      chk(tag, {19'd0, out_valid, flags, x}, {19'd0, 1'b1, exp});
      $display("op=%0d a=%h m=%h -> x=%h flags=%b", o, av, mv, x, flags);
   endtask

   initial begin
      logic [11:0] exp;
      logic [11:0] held;
      bit bad;
      bit seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; m = '0; op = '0;

      // Reset state
      tick(); tick();
      chk("rst_state", {19'd0, in_ready, out_valid, flags, x}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_release_ready0", 32'(in_ready), 32'd0);
      tick();
      chk("rst_release_ready1", 32'(in_ready), 32'd1);

      // Directed points
      do_op("add_ff_01", 4'd1, 8'hFF, 8'h01);
      chk("add_ff_01_const", {20'd0, flags, x}, {20'd0, 4'b0110, 8'h00});
      do_op("add_7f_01", 4'd1, 8'h7F, 8'h01);
      chk("add_7f_01_const", {20'd0, flags, x}, {20'd0, 4'b1001, 8'h80});
      do_op("sub_03_05", 4'd2, 8'h03, 8'h05);
      chk("sub_03_05_const", {24'd0, x}, 32'h0000_00FE);
      do_op("neg_01_02", 4'd4, 8'h01, 8'h02);
      chk("neg_01_02_const", {24'd0, x}, 32'h0000_00FD);
      do_op("sra_80_3", 4'd10, 8'h80, 8'h03);
      chk("sra_80_3_const", {24'd0, x}, 32'h0000_00F0);
      do_op("rol_81_1", 4'd11, 8'h81, 8'h01);
      chk("rol_81_1_const", {20'd0, flags[1], x}, {20'd0, 1'b1, 8'h03});
      do_op("shr_amt0", 4'd9, 8'hFF, 8'h08);
      do_op("mul_0f_11", 4'd12, 8'h0F, 8'h11);
      chk("mul_0f_11_const", {20'd0, flags, x}, {20'd0, 4'b1000, 8'hFF});
      do_op("mul_10_10", 4'd12, 8'h10, 8'h10);
      chk("mul_10_10_const", {20'd0, flags, x}, {20'd0, 4'b0110, 8'h00});
      do_op("reserved_14", 4'd14, 8'h00, 8'h5A);

      // Backpressure: result held, no new accept while stalled
      tick();
      out_ready = 1'b0;
      op = 4'd7; a = 8'($urandom); m = 8'($urandom); in_valid = 1'b1;
      exp = model(op, a, m);
      tick();
      chk("bp_first", {19'd0, out_valid, flags, x}, {19'd0, 1'b1, exp});
      held = {flags, x};
      op = 4'd1; a = ~a;
      bad = 0;
      repeat (5) begin
         tick();
         if (!out_valid || {flags, x} !== held || in_ready) bad = 1;
      end
      in_valid = 1'b0;
      chk("bp_hold", 32'(bad), 32'd0);
      $display("backpressure held x=%h flags=%b", x, flags);

      // Async reset while a result is held
      rst_n = 1'b0;
      #1;
      chk("rst_mid_zero", {19'd0, in_ready, out_valid, flags, x}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;

      // Streaming: one result per clock
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         op = 4'(5 + $urandom_range(0, 2)); a = 8'($urandom); m = 8'($urandom);
         in_valid = 1'b1;
         if (!in_ready) bad = 1;
         exp = model(op, a, m);
         tick();
         chk("stream", {19'd0, out_valid, flags, x}, {19'd0, 1'b1, exp});
         $display("stream op=%0d x=%h flags=%b", op, x, flags);
      end
      in_valid = 1'b0;
      chk("stream_ready", 32'(bad), 32'd0);
      tick();
      chk("stream_drop", 32'(out_valid), 32'd0);

      // Reset during MUL cycle 4: result must never appear
      op = 4'd12; a = 8'hA5; m = 8'h3C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mul_zero", {19'd0, in_ready, out_valid, flags, x}, 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         tick();
         if (out_valid) seen = 1;
      end
      chk("rst_mul_no_pulse", 32'(seen), 32'd0);
      do_op("add_02_03", 4'd1, 8'h02, 8'h03);
      chk("add_02_03_const", {24'd0, x}, 32'h0000_0005);

      // Randomized ops, including multiply and reserved codes
      for (int i = 0; i < 40; i++) begin
         do_op("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
